ps2_rx_deframer: RTL and testbench

Host-side PS/2 receiver that consumes the open-collector ps2clk/ps2data pair driven by the team's PS/2 device-side transmitter. Synchronises and deglitches both lines, detects ps2clk falling edges, deframes the 11-bit frame (start, 8 data LSB-first, odd parity, stop) and presents each good byte with a one-cycle valid strobe. Parity, framing and inter-bit timeout faults raise one-cycle error strobes.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_sync_filter.sv | 46 ++++
 rtl/ps2_rx_deframer.sv | 142 ++++++++++++++
 tb/tb_ps2_rx_deframer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic        PS2_START_BIT      = 1'b0;
    localparam logic        PS2_STOP_BIT       = 1'b1;
    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned PS2_FILTER_LEN_DEF = 8;
    localparam int unsigned PS2_TIMEOUT_DEF    = 4096;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a stability filter; output idles high.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int unsigned  CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] RUN_MAX = CW'(FILTER_LEN - 1);

    logic          meta_q, sync_q, filt_q, filt_d;
    logic [CW-1:0] run_q, run_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            run_q  <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    // Any sample agreeing with the current output restarts the run.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_q != filt_q) begin
            if (run_q == RUN_MAX) begin
                filt_d = sync_q;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/ps2_rx_deframer.sv
// PS/2 host receiver: filters both lines, detects ps2clk falls and deframes
// start/8 data/odd parity/stop into a byte with valid and error strobes.
module ps2_rx_deframer
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF,
    parameter int unsigned TIMEOUT    = PS2_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned  TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(PS2_DATA_BITS - 1);

    logic clk_filt, data_filt, clk_prev_q, fall, rx_bit;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2clk),
        .filt (clk_filt)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2data),
        .filt (data_filt)
    );

    assign fall   = clk_prev_q & ~clk_filt;
    assign rx_bit = data_filt;

    ps2_state_e                 state_q, state_d;
    logic [PS2_DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                       par_q, par_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic [7:0]                 data_q, data_d;
    logic                       valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_q <= 1'b1;
            state_q    <= StIdle;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_filt;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            tcnt_d  = '0;
        end else if (state_q != StIdle && tcnt_q == TMAX) begin
            // Expiry beats a coincident edge; that edge is dropped.
            state_d = StIdle;
            cnt_d   = '0;
            tcnt_d  = '0;
            ferr_d  = 1'b1;
        end else begin
            tcnt_d = (state_q == StIdle || fall) ? '0 : tcnt_q + 1'b1;
            if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_bit == PS2_START_BIT) begin
                            state_d = StData;
                            cnt_d   = '0;
                        end
                    end
                    StData: begin
                        shreg_d = {rx_bit, shreg_q[PS2_DATA_BITS-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) state_d = StParity;
                    end
                    StParity: begin
                        par_d   = rx_bit;
                        state_d = StStop;
                    end
                    StStop: begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        if (rx_bit != PS2_STOP_BIT) begin
                            ferr_d = 1'b1;
                        end else if (^{shreg_q, par_q} == 1'b0) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor checks them.
module tb_ps2_rx_deframer;

    localparam int FL = 8;
    localparam int TO = 4096;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    ps2_rx_deframer #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    // Returns #1 after the n-th following rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends start plus the first nbits of the 10 bits after it; returns k of the last fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half,
                             input int glitch_bit, output int k_last);
        for (int i = 0; i <= nbits; i++) begin
            ps2data = bits[i];
            wait_cyc(10);
            if (i == glitch_bit) begin
                ps2data = ~bits[i];
                wait_cyc(5);
                ps2data = bits[i];
            end
            wait_cyc(half - 15);
            ps2clk = 1'b0;
            k_last = cyc + 1;
            if (i == nbits) k_last = cyc + 1;
            wait_cyc(half);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int half,
                              input int kind, input logic [7:0] exp_data, input int glitch_bit);
        logic [10:0] bits;
        int          k;
        bits = {s, p, d, 1'b0};
        // Expected entry is pushed after the stop fall but before its strobe is due.
        send_bits(bits, 9, half, glitch_bit, k);
        ps2data = bits[10];
        wait_cyc(half - 15);
        ps2clk = 1'b0;
        k = cyc + 1;
        exp_q.push_back('{kind, exp_data, k + FL + 2});
        wait_cyc(half);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cyc(20);
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        int   n, kind;
        exp_t e;
        if (!rst) begin
            n = int'(valid) + int'(parity_err) + int'(frame_err);
            if (n > 1) begin
                check("strobe_exclusive", 32'(n), 32'd1);
            end else if (n == 1) begin
                kind = valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(kind), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'(kind), 32'(e.kind));
                    check("strobe_data", 32'(data), 32'(e.dat));
                    check("strobe_cycle", 32'(cyc), 32'(e.at));
                    check("strobe_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        wait_cyc(3);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_cyc(20);

        // Good frame, slow ps2clk.
        send_frame(8'hA5, 1'b1, 1'b1, 512, K_VALID, 8'hA5, -1);
        // Wrong parity: data must hold 0xA5.
        send_frame(8'h3C, 1'b0, 1'b1, 128, K_PERR, 8'hA5, -1);
        // Bad stop bit, then the same byte framed correctly.
        send_frame(8'h12, 1'b1, 1'b0, 128, K_FERR, 8'hA5, -1);
        send_frame(8'h12, 1'b1, 1'b1, 128, K_VALID, 8'h12, -1);

        // Abort after 4 data bits; ps2clk stays high until timeout.
        send_bits({2'b11, 8'h0F, 1'b0}, 4, 128, -1, k);
        exp_q.push_back('{K_FERR, 8'h12, k + FL + 2 + TO});
        check("busy_mid_abort", 32'(busy), 32'd1);
        wait_cyc(TO);
        check("busy_after_timeout", 32'(busy), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b1, 128, K_VALID, 8'h7E, -1);

        // Short ps2clk glitch in idle, then a ps2data glitch inside bit 3.
        ps2clk = 1'b0;
        wait_cyc(5);
        ps2clk = 1'b1;
        wait_cyc(30);
        check("busy_after_clk_glitch", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, 128, K_VALID, 8'h5A, 3);

        // Reset mid-frame.
        send_bits({2'b11, 8'hFF, 1'b0}, 3, 128, -1, k);
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_strobes", 32'({valid, parity_err, frame_err}), 32'd0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        send_frame(8'hC3, 1'b1, 1'b1, 128, K_VALID, 8'hC3, -1);

        // Enable dropped mid-frame.
        send_bits({2'b11, 8'h00, 1'b0}, 3, 128, -1, k);
        check("busy_before_disable", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_cyc(1);
        check("disable_busy", 32'(busy), 32'd0);
        check("disable_data_held", 32'(data), 32'hC3);
        wait_cyc(20);
        enable = 1'b1;
        wait_cyc(20);
        send_frame(8'h81, 1'b1, 1'b1, 128, K_VALID, 8'h81, -1);

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) wait_cyc(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
